positron_layer_seq: RTL and testbench
=====================================

# positron_layer_seq

Frame sequencer and result serializer for a positron layer. It sits between the upstream posit stream (DMA or the previous layer) and an external array of NB_POSITRON positrons. It counts input words into frames and drives sow/eow to the array. It flags short frames, tags each frame with its DMA-last status, and captures the array's parallel results into a ping-pong buffer. It then streams those results out OUT_LANES posits per beat with lane keep, under full backpressure.

## Interface
- POSIT_WIDTH, 16, bits per posit
- NB_UPSTREAM_POSITRON, 784, nominal words per frame (≥1)
- NB_POSITRON, 20, results per frame
- OUT_LANES, 1, posits per output beat (1..NB_POSITRON)
- TLAST_MODE, 0, 0: eow_o only on frames closed by eow_i; 1: eow_o on every frame
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rts_i / rtr_o  in/out  1  upstream valid/ready
- eow_i  in  1  DMA last word
- posit_i  in  POSIT_WIDTH  upstream word
- pe_rts_o / pe_rtr_i  out/in  1  array input valid/ready
- pe_sow_o, pe_eow_o  out  1  frame first/last word to array
- pe_posit_o  out  POSIT_WIDTH  word to array
- res_rts_i / res_rtr_o  in/out  1  array result valid/ready
- res_data_i  in  NB_POSITRON*POSIT_WIDTH  results; index k at bits [k*W +: W]
- rts_o / rtr_i  out/in  1  downstream valid/ready
- eow_o  out  1  last beat of a tagged frame
- keep_o  out  OUT_LANES  lane valid mask
- posit_o  out  OUT_LANES*POSIT_WIDTH  lane l at bits [l*W +: W]
- short_frame_o  out  1  one-cycle pulse
- frame_cnt_o  out  16  closed-frame count, wraps
- err_o  out  1  sticky protocol error

## Operation
- Input path is combinational: pe_rts_o = rts_i, pe_posit_o = posit_i, rtr_o = pe_rtr_i & !tagq_full. Accept = rts_i & rtr_o.
- Word counter wc covers 0..N-1, where N = NB_UPSTREAM_POSITRON.
  - pe_sow_o = rts_i & (wc==0).
  - pe_eow_o = rts_i & (wc==N-1 | eow_i).
  - On accept: wc resets to 0 if pe_eow_o is asserted, otherwise wc increments.
- Frame close is an accept with pe_eow_o asserted. On frame close:
  - frame_cnt_o increments.
  - Push tag = eow_i into the 2-entry tag FIFO (tagq).
  - If eow_i is set and wc < N-1, short_frame_o pulses on the next cycle.
  - eow_i at wc==N-1 is a normal close, not a short frame.
  - eow_i at wc==0 produces a one-word frame with sow and eow both asserted.
- Two result banks, each holding NB_POSITRON words, a tag bit and a full flag.
  - res_rtr_o = !full[wr_bank] (registered).
  - On res_rts_i & res_rtr_o: capture res_data_i into the bank, pop tagq into the bank tag, set full, toggle wr_bank.
  - If tagq is empty at capture, the tag is 0 and err_o is set (sticky until rst).
- Output FSM has two states, IDLE and STREAM, plus a beat counter b over 0..B-1, where B = ceil(NB_POSITRON/OUT_LANES).
  - IDLE → STREAM when full[rd_bank] is set; rts_o rises on the next cycle.
  - Lane l of beat b carries result b*OUT_LANES+l. If that index is ≥ NB_POSITRON, keep is 0 and data is 0.
  - eow_o = (b==B-1) & (tag | TLAST_MODE).
  - On rts_o & rtr_i: b increments. On the last beat: clear full[rd_bank], toggle rd_bank, b=0. Go to STREAM again if the other bank is full, otherwise IDLE.
- All output-side signals are registered: rts_o, eow_o, keep_o, posit_o, short_frame_o, frame_cnt_o, err_o, res_rtr_o.

## Timing
- Reset values:
  - rts_o=0, eow_o=0, keep_o=0, posit_o=0, short_frame_o=0, frame_cnt_o=0, err_o=0.
  - res_rtr_o=1, wc=0, tagq empty, both banks empty, FSM in IDLE.
  - After reset, rtr_o equals pe_rtr_i.
- Latency from result capture at cycle t to first beat rts_o is t+1.
- A bank freed by the last-beat handshake at cycle t is visible on res_rtr_o at t+1. There is no same-cycle reuse.
- Back-to-back frames stream with no idle beat while the other bank is full.
- While rts_o=1 and rtr_i=0, posit_o, keep_o and eow_o hold stable.
- With tagq full, rtr_o=0; it recovers the cycle after a capture pops tagq.
- Asserting rst mid-frame or mid-stream discards all state immediately.

## Test plan
- **Basic frame.** N=4, NB_POSITRON=5, OUT_LANES=2, TLAST_MODE=0. Send 4 words with eow_i on word 4 → pe_sow_o on word 1, pe_eow_o on word 4, short_frame_o=0, frame_cnt_o=1. Then results 1..5 → beats (1,2) keep 11, (3,4) keep 11, (5,0) keep 01; eow_o=1 only on beat 3.
- **Short frame.** N=4, eow_i on word 2 → pe_eow_o on word 2, one short_frame_o pulse, next word has pe_sow_o=1, frame_cnt_o +1.
- **Tag propagation.** Frame A is 4 words without eow_i, frame B is 4 words with eow_i on word 4.
  - TLAST_MODE=0 → A streams with no eow_o, B streams with eow_o.
  - TLAST_MODE=1 → both frames end with eow_o.
- **Backpressure.**
  - Hold rtr_i low 3 cycles mid-stream → output stable for those 3 cycles.
  - A second result is captured into the other bank.
  - A third res_rts_i sees res_rtr_o=0 until one cycle after the first bank's last beat.
- **Tag FIFO full and error.**
  - Close 2 frames with no results → rtr_o=0.
  - One capture → rtr_o=1 on the next cycle.
  - A result with tagq empty → err_o=1, held sticky.
- **Reset mid-operation.** Assert rst during beat 2 → all outputs at reset values and frame_cnt_o=0. The next frame starts with pe_sow_o on its first word.

Source files
------------

// File: rtl/positron_layer_seq.sv
// ---------------------------------------------------------------------------
// positron_layer_seq
//
// Frame sequencer and result serializer for a positron layer.
//
// The upstream posit stream passes straight through to the positron array.
// This block counts the words into frames and marks the first and last word
// of each frame (pe_sow_o / pe_eow_o). Each closed frame pushes its DMA-last
// status into a small tag FIFO. When the array presents its parallel
// results, they are captured into one of two ping-pong banks together with
// the oldest tag. The banks are then streamed downstream OUT_LANES posits
// per beat, with a lane keep mask, under full backpressure.
//
// Parameters
//   POSIT_WIDTH           bits per posit
//   NB_UPSTREAM_POSITRON  nominal words per frame (>= 1)
//   NB_POSITRON           results per frame
//   OUT_LANES             posits per output beat (1..NB_POSITRON)
//   TLAST_MODE            0: eow_o only on frames closed by eow_i,
//                         1: eow_o on every frame
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rts_i / rtr_o            upstream valid / ready
//   eow_i, posit_i           upstream DMA-last flag and word
//   pe_rts_o / pe_rtr_i      array input valid / ready
//   pe_sow_o, pe_eow_o       frame first / last word to the array
//   pe_posit_o               word to the array
//   res_rts_i / res_rtr_o    array result valid / ready
//   res_data_i               results, index k at bits [k*W +: W]
//   rts_o / rtr_i            downstream valid / ready
//   eow_o                    last beat of a tagged frame
//   keep_o                   lane valid mask
//   posit_o                  output lanes, lane l at bits [l*W +: W]
//   short_frame_o            one-cycle pulse after a frame closed early
//   frame_cnt_o              closed-frame count, wraps
//   err_o                    sticky: result arrived with no pending tag
// ---------------------------------------------------------------------------
module positron_layer_seq #(
    parameter int POSIT_WIDTH          = 16,
    parameter int NB_UPSTREAM_POSITRON = 784,
    parameter int NB_POSITRON          = 20,
    parameter int OUT_LANES            = 1,
    parameter int TLAST_MODE           = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    // upstream stream
    input  logic                                rts_i,
    output logic                                rtr_o,
    input  logic                                eow_i,
    input  logic [POSIT_WIDTH-1:0]              posit_i,
    // array input
    output logic                                pe_rts_o,
    input  logic                                pe_rtr_i,
    output logic                                pe_sow_o,
    output logic                                pe_eow_o,
    output logic [POSIT_WIDTH-1:0]              pe_posit_o,
    // array results
    input  logic                                res_rts_i,
    output logic                                res_rtr_o,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0]  res_data_i,
    // downstream stream
    output logic                                rts_o,
    input  logic                                rtr_i,
    output logic                                eow_o,
    output logic [OUT_LANES-1:0]                keep_o,
    output logic [OUT_LANES*POSIT_WIDTH-1:0]    posit_o,
    // status
    output logic                                short_frame_o,
    output logic [15:0]                         frame_cnt_o,
    output logic                                err_o
);

    localparam int W        = POSIT_WIDTH;
    localparam int N        = NB_UPSTREAM_POSITRON;
    localparam int RES_W    = NB_POSITRON * W;
    localparam int OUT_W    = OUT_LANES * W;
    localparam int NB_BEATS = (NB_POSITRON + OUT_LANES - 1) / OUT_LANES;
    localparam int WC_W     = (N > 1) ? $clog2(N) : 1;
    localparam int B_W      = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(N - 1);
    localparam logic [B_W-1:0]  B_LAST  = B_W'(NB_BEATS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input path and framing
    // ------------------------------------------------------------------
    logic [WC_W-1:0] wc;
    logic            accept;
    logic            frame_close;

    // Tag FIFO: two entries, head always at index 0.
    logic [1:0]      tq_mem;
    logic [1:0]      tq_mem_nxt;
    logic [1:0]      tq_cnt;
    logic [1:0]      tq_cnt_nxt;
    logic            tagq_full;
    logic            tag_pop;
    logic            cap_tag;

    // Result capture
    logic            cap;
    logic [RES_W-1:0] bank_data [2];
    logic [1:0]      bank_tag;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic [1:0]      full_eff;
    logic            wr_bank;
    logic            rd_bank;
    logic            rd_bank_nxt;

    // Output FSM
    state_t          state;
    state_t          state_nxt;
    logic [B_W-1:0]  beat;
    logic [B_W-1:0]  beat_nxt;
    logic            handshake;
    logic            last_hs;

    // Next values of the registered beat outputs
    logic [RES_W-1:0] sel_data;
    logic             sel_tag;
    logic [OUT_W-1:0] posit_nxt;
    logic [OUT_LANES-1:0] keep_nxt;
    logic             eow_nxt;
    int               idx;

    assign tagq_full   = (tq_cnt == 2'd2);
    assign rtr_o       = pe_rtr_i & ~tagq_full;
    assign pe_rts_o    = rts_i;
    assign pe_posit_o  = posit_i;
    assign pe_sow_o    = rts_i & (wc == '0);
    assign pe_eow_o    = rts_i & ((wc == WC_LAST) | eow_i);
    assign accept      = rts_i & rtr_o;
    assign frame_close = accept & pe_eow_o;

    // Word counter, frame counter and short-frame pulse. A frame closed by
    // eow_i exactly on the nominal last word is a normal close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc            <= '0;
            frame_cnt_o   <= '0;
            short_frame_o <= 1'b0;
        end else begin
            short_frame_o <= frame_close & eow_i & (wc != WC_LAST);
            if (accept) begin
                wc <= pe_eow_o ? '0 : wc + WC_W'(1);
            end
            if (frame_close) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO. A pop (result capture) and a push (frame close) can land in
    // the same cycle; the pop shifts first so the push goes behind it.
    // ------------------------------------------------------------------
    assign cap     = res_rts_i & res_rtr_o;
    assign tag_pop = cap & (tq_cnt != 2'd0);
    assign cap_tag = tag_pop & tq_mem[0];

    always_comb begin
        tq_mem_nxt = tq_mem;
        tq_cnt_nxt = tq_cnt;
        if (tag_pop) begin
            tq_mem_nxt[0] = tq_mem[1];
            tq_cnt_nxt    = tq_cnt - 2'd1;
        end
        if (frame_close) begin
            tq_mem_nxt[tq_cnt_nxt[0]] = eow_i;
            tq_cnt_nxt                = tq_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tq_mem <= '0;
            tq_cnt <= '0;
        end else begin
            tq_mem <= tq_mem_nxt;
            tq_cnt <= tq_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong banks. Capture and release always target different banks:
    // capture needs the write bank empty, release needs the read bank full.
    // ------------------------------------------------------------------
    always_comb begin
        full_nxt = full;
        if (cap) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (last_hs) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Bank occupancy including a capture happening this cycle, so the
    // streamer can start (or continue) without waiting a cycle for the flag.
    always_comb begin
        full_eff = full;
        if (cap) begin
            full_eff[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            bank_tag  <= '0;
            wr_bank   <= 1'b0;
            res_rtr_o <= 1'b1;
            err_o     <= 1'b0;
        end else begin
            full      <= full_nxt;
            wr_bank   <= wr_bank ^ cap;
            res_rtr_o <= ~full_nxt[wr_bank ^ cap];
            if (cap) begin
                bank_tag[wr_bank] <= cap_tag;
                if (tq_cnt == 2'd0) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    // Result payload needs no reset; it is only read while its bank is full.
    always_ff @(posedge clk) begin
        if (cap) begin
            bank_data[wr_bank] <= res_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    assign rts_o     = (state == STREAM);
    assign handshake = rts_o & rtr_i;
    assign last_hs   = handshake & (beat == B_LAST);

    // State register, together with the registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            rd_bank <= 1'b0;
            posit_o <= '0;
            keep_o  <= '0;
            eow_o   <= 1'b0;
        end else begin
            state   <= state_nxt;
            beat    <= beat_nxt;
            rd_bank <= rd_bank_nxt;
            posit_o <= posit_nxt;
            keep_o  <= keep_nxt;
            eow_o   <= eow_nxt;
        end
    end

    // Next state. After the last beat the other bank follows immediately
    // when it is already full, so back-to-back frames have no idle beat.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        rd_bank_nxt = rd_bank;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (full_eff[rd_bank]) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (beat == B_LAST) begin
                        beat_nxt    = '0;
                        rd_bank_nxt = ~rd_bank;
                        state_nxt   = full_eff[~rd_bank] ? STREAM : IDLE;
                    end else begin
                        beat_nxt = beat + B_W'(1);
                    end
                end
            end
        endcase
    end

    // Beat contents for the next cycle. Recomputing from the same bank and
    // beat while stalled keeps the outputs stable, since a full bank is
    // never overwritten. Lanes past the last result carry keep=0, data=0.
    always_comb begin
        sel_data  = bank_data[rd_bank_nxt];
        sel_tag   = bank_tag[rd_bank_nxt];
        posit_nxt = '0;
        keep_nxt  = '0;
        eow_nxt   = 1'b0;
        idx       = 0;
        if (cap && (wr_bank == rd_bank_nxt)) begin
            sel_data = res_data_i;
            sel_tag  = cap_tag;
        end
        if (state_nxt == STREAM) begin
            for (int l = 0; l < OUT_LANES; l++) begin
                idx = int'(beat_nxt) * OUT_LANES + l;
                if (idx < NB_POSITRON) begin
                    keep_nxt[l]          = 1'b1;
                    posit_nxt[l*W +: W]  = sel_data[idx*W +: W];
                end
            end
            eow_nxt = (beat_nxt == B_LAST) & (sel_tag | (TLAST_MODE != 0));
        end
    end

endmodule

// File: tb/tb_positron_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_positron_layer_seq
//
// Self-checking bench for positron_layer_seq with a small configuration
// (4 words per frame, 5 results, 2 lanes, tags honoured). A reference model
// tracks frames, the tag queue and the expected output beats; a monitor
// compares every presented beat with the head of the expected-beat queue.
// ---------------------------------------------------------------------------
module tb_positron_layer_seq;

    localparam int W      = 16;
    localparam int N      = 4;
    localparam int NB     = 5;
    localparam int OL     = 2;
    localparam int TLAST  = 0;
    localparam int NBEATS = (NB + OL - 1) / OL;

    typedef struct packed {
        logic [OL*W-1:0] data;
        logic [OL-1:0]   keep;
        logic            eow;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              rts_i;
    logic              rtr_o;
    logic              eow_i;
    logic [W-1:0]      posit_i;
    logic              pe_rts_o;
    logic              pe_rtr_i;
    logic              pe_sow_o;
    logic              pe_eow_o;
    logic [W-1:0]      pe_posit_o;
    logic              res_rts_i;
    logic              res_rtr_o;
    logic [NB*W-1:0]   res_data_i;
    logic              rts_o;
    logic              rtr_i;
    logic              eow_o;
    logic [OL-1:0]     keep_o;
    logic [OL*W-1:0]   posit_o;
    logic              short_frame_o;
    logic [15:0]       frame_cnt_o;
    logic              err_o;

    int    checks = 0;
    int    errors = 0;

    // reference model state
    beat_t sb[$];
    bit    model_tq[$];
    int    model_wc = 0;
    int    model_frames = 0;
    bit    model_err = 0;

    // stimulus control
    bit    bp_hold = 0;
    bit    bp_rand = 0;
    bit    pe_rand = 0;

    positron_layer_seq #(
        .POSIT_WIDTH          (W),
        .NB_UPSTREAM_POSITRON (N),
        .NB_POSITRON          (NB),
        .OUT_LANES            (OL),
        .TLAST_MODE           (TLAST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rts_i         (rts_i),
        .rtr_o         (rtr_o),
        .eow_i         (eow_i),
        .posit_i       (posit_i),
        .pe_rts_o      (pe_rts_o),
        .pe_rtr_i      (pe_rtr_i),
        .pe_sow_o      (pe_sow_o),
        .pe_eow_o      (pe_eow_o),
        .pe_posit_o    (pe_posit_o),
        .res_rts_i     (res_rts_i),
        .res_rtr_o     (res_rtr_o),
        .res_data_i    (res_data_i),
        .rts_o         (rts_o),
        .rtr_i         (rtr_i),
        .eow_o         (eow_o),
        .keep_o        (keep_o),
        .posit_o       (posit_o),
        .short_frame_o (short_frame_o),
        .frame_cnt_o   (frame_cnt_o),
        .err_o         (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready driver; the directed tests take over via bp_hold.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!bp_hold) rtr_i = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: while a beat is presented it must equal the expected head;
    // the head is retired only when the beat is accepted.
    always @(negedge clk) begin
        if (!rst && rts_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected beat: posit_o=%0h keep_o=%0b", posit_o, keep_o);
            end else begin
                check("beat posit_o", 64'(posit_o), 64'(sb[0].data));
                check("beat keep_o", 64'(keep_o), 64'(sb[0].keep));
                check("beat eow_o", 64'(eow_o), 64'(sb[0].eow));
                if (rtr_i) void'(sb.pop_front());
            end
        end
    end

    // Expected beats for one captured result set.
    task automatic push_frame(input logic [NB*W-1:0] r, input bit tag);
        beat_t e;
        int    k;
        for (int b = 0; b < NBEATS; b++) begin
            e = '0;
            for (int l = 0; l < OL; l++) begin
                k = b * OL + l;
                if (k < NB) begin
                    e.data[l*W +: W] = r[k*W +: W];
                    e.keep[l]        = 1'b1;
                end
            end
            e.eow = (b == NBEATS - 1) && (tag || (TLAST != 0));
            sb.push_back(e);
        end
    endtask

    function automatic logic [NB*W-1:0] rand_results();
        logic [NB*W-1:0] r;
        for (int k = 0; k < NB; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " rts_o"}, 64'(rts_o), 64'd0);
        check({tag, " eow_o"}, 64'(eow_o), 64'd0);
        check({tag, " keep_o"}, 64'(keep_o), 64'd0);
        check({tag, " posit_o"}, 64'(posit_o), 64'd0);
        check({tag, " short_frame_o"}, 64'(short_frame_o), 64'd0);
        check({tag, " frame_cnt_o"}, 64'(frame_cnt_o), 64'd0);
        check({tag, " err_o"}, 64'(err_o), 64'd0);
        check({tag, " res_rtr_o"}, 64'(res_rtr_o), 64'd1);
    endtask

    // One upstream word; entered and left at posedge+1.
    task automatic apply_stimulus(input bit eow, input logic [W-1:0] data);
        bit accepted;
        bit exp_eow;
        bit exp_short;
        int guard;
        accepted = 0;
        guard    = 0;
        while (!accepted && guard < 100) begin
            rts_i    = 1'b1;
            eow_i    = eow;
            posit_i  = data;
            pe_rtr_i = pe_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            exp_eow = (model_wc == N - 1) || eow;
            check("rtr_o", 64'(rtr_o), 64'(pe_rtr_i && (model_tq.size() < 2)));
            check("pe_rts_o", 64'(pe_rts_o), 64'd1);
            check("pe_posit_o", 64'(pe_posit_o), 64'(data));
            check("pe_sow_o", 64'(pe_sow_o), 64'(model_wc == 0));
            check("pe_eow_o", 64'(pe_eow_o), 64'(exp_eow));
            accepted = rtr_o;
            @(posedge clk);
            #1;
            if (accepted) begin
                exp_short = exp_eow && eow && (model_wc < N - 1);
                if (exp_eow) begin
                    model_frames++;
                    model_tq.push_back(eow);
                    model_wc = 0;
                end else begin
                    model_wc++;
                end
                check("frame_cnt_o", 64'(frame_cnt_o), 64'(16'(model_frames)));
                check("short_frame_o", 64'(short_frame_o), 64'(exp_short));
            end else begin
                check("short_frame_o idle", 64'(short_frame_o), 64'd0);
                guard++;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL word accept timeout: rtr_o=%0b", rtr_o);
        end
        rts_i    = 1'b0;
        eow_i    = 1'b0;
        pe_rtr_i = 1'b1;
    endtask

    task automatic send_frame(input int len, input bit eow_last);
        for (int i = 0; i < len; i++) begin
            apply_stimulus(eow_last && (i == len - 1), W'($urandom));
        end
    endtask

    // One result capture; entered and left at posedge+1.
    task automatic send_result(input logic [NB*W-1:0] r);
        int guard;
        bit tag;
        guard      = 0;
        res_rts_i  = 1'b1;
        res_data_i = r;
        #1;
        while (!res_rtr_o && guard < 500) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!res_rtr_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL result accept timeout: res_rtr_o=%0b", res_rtr_o);
            res_rts_i = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            if (model_tq.size() > 0) begin
                tag = model_tq.pop_front();
            end else begin
                tag       = 1'b0;
                model_err = 1'b1;
            end
            push_frame(r, tag);
            @(posedge clk);
            #1;
            res_rts_i = 1'b0;
            check("err_o", 64'(err_o), 64'(model_err));
        end
    endtask

    task automatic check_output_drained();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || rts_o) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (sb.size() != 0 || rts_o) begin
            errors++;
            $display("[TB] FAIL drain: %0d beats still expected, rts_o=%0b", sb.size(), rts_o);
        end
    endtask

    initial begin
        logic [NB*W-1:0] r;

        rst        = 1'b1;
        rts_i      = 1'b0;
        eow_i      = 1'b0;
        posit_i    = '0;
        pe_rtr_i   = 1'b1;
        res_rts_i  = 1'b0;
        res_data_i = '0;
        rtr_i      = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset rtr_o follows pe_rtr_i=1", 64'(rtr_o), 64'd1);
        pe_rtr_i = 1'b0;
        #1;
        check("reset rtr_o follows pe_rtr_i=0", 64'(rtr_o), 64'd0);
        pe_rtr_i = 1'b1;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame: 4 words with eow on the last, results 1..5
        $display("[TB] basic frame");
        for (int i = 1; i <= 4; i++) apply_stimulus(i == 4, W'(i));
        for (int k = 0; k < NB; k++) r[k*W +: W] = W'(k + 1);
        send_result(r);
        check("first beat one cycle after capture", 64'(rts_o), 64'd1);
        check_output_drained();

        // Short frame, then frame A without eow fills the tag queue
        $display("[TB] short frame and tag queue full");
        apply_stimulus(1'b0, W'(16'h0a01));
        apply_stimulus(1'b1, W'(16'h0a02));
        send_frame(4, 1'b0);
        rts_i    = 1'b1;
        posit_i  = W'(16'h0bad);
        pe_rtr_i = 1'b1;
        #1;
        check("rtr_o with tag queue full", 64'(rtr_o), 64'd0);
        check("pe_sow_o while blocked", 64'(pe_sow_o), 64'd1);
        rts_i = 1'b0;
        @(posedge clk);
        #1;
        send_result(rand_results());
        check("rtr_o after tag pop", 64'(rtr_o), 64'd1);
        send_result(rand_results());
        // Frame B closed by eow on its nominal last word
        send_frame(4, 1'b1);
        send_result(rand_results());
        check_output_drained();

        // Backpressure and ping-pong occupancy
        $display("[TB] backpressure");
        bp_hold = 1'b1;
        rtr_i   = 1'b0;
        send_frame(4, 1'b0);
        send_frame(4, 1'b1);
        send_result(rand_results());
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send_result(rand_results());
        check("res_rtr_o with both banks full", 64'(res_rtr_o), 64'd0);
        send_frame(4, 1'b0);
        rtr_i = 1'b1;
        check("res_rtr_o before first beat", 64'(res_rtr_o), 64'd0);
        @(posedge clk);
        #1;
        check("res_rtr_o after beat 1", 64'(res_rtr_o), 64'd0);
        @(posedge clk);
        #1;
        check("res_rtr_o after beat 2", 64'(res_rtr_o), 64'd0);
        @(posedge clk);
        #1;
        check("res_rtr_o after last beat", 64'(res_rtr_o), 64'd1);
        send_result(rand_results());
        bp_hold = 1'b0;
        check_output_drained();

        // Result with no pending tag
        $display("[TB] tag queue empty error");
        send_result(rand_results());
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("err_o sticky", 64'(err_o), 64'd1);
        check_output_drained();

        // Reset during the second beat with a partial frame in flight
        $display("[TB] reset mid-operation");
        send_frame(4, 1'b0);
        apply_stimulus(1'b0, W'(16'h0c01));
        apply_stimulus(1'b0, W'(16'h0c02));
        bp_hold = 1'b1;
        rtr_i   = 1'b0;
        send_result(rand_results());
        rtr_i = 1'b1;
        @(posedge clk);
        #1;
        rtr_i = 1'b0;
        rst   = 1'b1;
        sb.delete();
        model_tq.delete();
        model_wc     = 0;
        model_frames = 0;
        model_err    = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        bp_hold = 1'b0;
        send_frame(4, 1'b1);
        send_result(rand_results());
        check_output_drained();

        // Randomized frames, ready stalls and backpressure
        $display("[TB] random traffic");
        bp_rand = 1'b1;
        pe_rand = 1'b1;
        for (int it = 0; it < 16; it++) begin
            int len;
            bit eow_last;
            len      = $urandom_range(1, 4);
            eow_last = (len < 4) || ($urandom_range(0, 1) != 0);
            send_frame(len, eow_last);
            send_result(rand_results());
        end
        bp_rand = 1'b0;
        pe_rand = 1'b0;
        check_output_drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
